// File: rtl/g15_timing_pkg.sv
// Shared G-15 drum timing constants, counter types and run-control states.
package g15_timing_pkg;

    localparam int G15_BITS  = 29;
    localparam int G15_WORDS = 108;

    typedef logic [$clog2(G15_BITS)-1:0]  bit_time_t;
    typedef logic [$clog2(G15_WORDS)-1:0] word_time_t;

    typedef enum logic [2:0] {HALT, ARM, RUN, DRAIN, STEP} seq_state_t;

endpackage

// File: rtl/drum_counter.sv
// Free-running bit/word counters modelling drum rotation; advance on tick only.
module drum_counter
    import g15_timing_pkg::*;
#(
    parameter int BITS  = G15_BITS,
    parameter int WORDS = G15_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    output logic [$clog2(BITS)-1:0]  bit_time,
    output logic [$clog2(WORDS)-1:0] word_time,
    output logic                     wb,
    output logic                     word_start,
    output logic                     rev_start
);

    localparam int BW = $clog2(BITS);
    localparam int WW = $clog2(WORDS);

    logic [BW-1:0] r_bit;
    logic [WW-1:0] r_word;
    logic          w_bit_last;
    logic          w_word_last;

    assign w_bit_last  = (r_bit == BW'(BITS - 1));
    assign w_word_last = (r_word == WW'(WORDS - 1));

    // Boundary strobes are masked during reset so they read 0 while counters clear.
    assign wb         = tick && !rst && w_bit_last;
    assign word_start = wb;
    assign rev_start  = wb && w_word_last;
    assign bit_time   = r_bit;
    assign word_time  = r_word;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit  <= '0;
            r_word <= '0;
        end else if (tick) begin
            r_bit <= w_bit_last ? '0 : r_bit + 1'b1;
            if (w_bit_last)
                r_word <= w_word_last ? '0 : r_word + 1'b1;
        end
    end

endmodule

// File: rtl/drum_sequencer.sv
// G-15 execution sequencer: drum counters plus go/stop/step run control in whole words.
// Optional short-line timing outputs (sl_time, sl_start) enabled by G15_SHORT_LINE_EN.
module drum_sequencer
    import g15_timing_pkg::*;
#(
    parameter int BITS  = G15_BITS,
    parameter int WORDS = G15_WORDS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tick,
    input  logic                     go,
    input  logic                     step,
    input  logic                     stop,
    output logic [$clog2(BITS)-1:0]  bit_time,
    output logic [$clog2(WORDS)-1:0] word_time,
    output logic                     word_start,
    output logic                     rev_start,
    output logic                     exec,
    output logic                     busy
`ifdef G15_SHORT_LINE_EN
    ,
    output logic [1:0]               sl_time,
    output logic                     sl_start
`endif
);

    logic       w_wb;
    seq_state_t r_state, w_state_nxt;
    logic       r_mode_step, w_mode_step_nxt;

    drum_counter #(.BITS(BITS), .WORDS(WORDS)) u_cnt (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .bit_time   (bit_time),
        .word_time  (word_time),
        .wb         (w_wb),
        .word_start (word_start),
        .rev_start  (rev_start)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HALT;
            r_mode_step <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_step <= w_mode_step_nxt;
        end
    end

    // stop outranks go, which outranks step; all decisions use the pre-boundary state.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_step_nxt = r_mode_step;
        case (r_state)
            HALT: begin
                if (!stop && go) begin
                    w_state_nxt     = ARM;
                    w_mode_step_nxt = 1'b0;
                end else if (!stop && step) begin
                    w_state_nxt     = ARM;
                    w_mode_step_nxt = 1'b1;
                end
            end
            ARM: begin
                if (stop)
                    w_state_nxt = HALT;
                else if (w_wb)
                    w_state_nxt = r_mode_step ? STEP : RUN;
            end
            RUN:         if (stop) w_state_nxt = DRAIN;
            DRAIN, STEP: if (w_wb) w_state_nxt = HALT;
            default:     w_state_nxt = HALT;
        endcase
    end

    assign exec = (r_state == RUN) || (r_state == DRAIN) || (r_state == STEP);
    assign busy = (r_state != HALT);

`ifdef G15_SHORT_LINE_EN
    if (WORDS % 4 != 0) begin : g_sl_chk
        $error("drum_sequencer: WORDS must be a multiple of 4 for short-line timing");
    end

    // With WORDS a multiple of 4 the low word bits wrap in lockstep with word_time.
    assign sl_time  = word_time[1:0];
    assign sl_start = w_wb && (sl_time == 2'd3);
`endif

endmodule

// File: tb/tb_drum_sequencer.sv
// Scoreboard bench for drum_sequencer: spec-level model predicts each clk, plus directed timing checks.
module tb_drum_sequencer;

    localparam int BITS  = 29;
    localparam int WORDS = 108;

    logic       clk = 1'b0;
    logic       rst = 1'b1, tick = 1'b0, go = 1'b0, step = 1'b0, stop = 1'b0;
    logic [4:0] bit_time;
    logic [6:0] word_time;
    logic       word_start, rev_start, exec, busy;
`ifdef G15_SHORT_LINE_EN
    logic [1:0] sl_time;
    logic       sl_start;
`endif

    drum_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .go         (go),
        .step       (step),
        .stop       (stop),
        .bit_time   (bit_time),
        .word_time  (word_time),
        .word_start (word_start),
        .rev_start  (rev_start),
        .exec       (exec),
        .busy       (busy)
`ifdef G15_SHORT_LINE_EN
        ,
        .sl_time    (sl_time),
        .sl_start   (sl_start)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int bt;
        int wt;
        int ex;
        int bz;
    } exp_t;

    exp_t sb_q[$];
    int   errs = 0, checks = 0;

    // model state (0 HALT, 1 ARM, 2 RUN, 3 DRAIN, 4 STEP)
    int m_bit = 0, m_word = 0, m_st = 0, m_step = 0;

    int   ws_cnt = 0, rs_cnt = 0, rs_bit = -1, rs_word = -1;
    int   rise_bit = -1, rise_word = -1, fall_bit = -1, fall_word = -1;
    int   hi_bit = -1, hi_word = -1, ex_ticks = 0;
    logic prev_ex = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic t, input logic g, input logic s, input logic p, input logic r);
        exp_t e;
        int   wb;
        @(negedge clk);
        tick = t; go = g; step = s; stop = p; rst = r;
        #1;
        wb = (t && !r && m_bit == BITS - 1) ? 1 : 0;
        chk("word_start", int'(word_start), wb);
        chk("rev_start", int'(rev_start), (wb == 1 && m_word == WORDS - 1) ? 1 : 0);
`ifdef G15_SHORT_LINE_EN
        chk("sl_start", int'(sl_start), (wb == 1 && m_word % 4 == 3) ? 1 : 0);
`endif
        if (word_start) ws_cnt++;
        if (rev_start) begin
            rs_cnt++;
            rs_bit  = int'(bit_time);
            rs_word = int'(word_time);
        end
        if (t && exec) ex_ticks++;
        if (exec) begin
            hi_bit  = int'(bit_time);
            hi_word = int'(word_time);
        end
        if (r) begin
            m_bit = 0; m_word = 0; m_st = 0; m_step = 0;
        end else begin
            case (m_st)
                0: begin
                    if (!p && g) begin m_st = 1; m_step = 0; end
                    else if (!p && s) begin m_st = 1; m_step = 1; end
                end
                1: begin
                    if (p) m_st = 0;
                    else if (wb == 1) m_st = (m_step == 1) ? 4 : 2;
                end
                2: if (p) m_st = 3;
                3, 4: if (wb == 1) m_st = 0;
                default: m_st = 0;
            endcase
            if (t) begin
                if (m_bit == BITS - 1) begin
                    m_bit  = 0;
                    m_word = (m_word == WORDS - 1) ? 0 : m_word + 1;
                end else begin
                    m_bit++;
                end
            end
        end
        e.bt = m_bit; e.wt = m_word;
        e.ex = (m_st >= 2) ? 1 : 0;
        e.bz = (m_st != 0) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("bit_time", int'(bit_time), e.bt);
        chk("word_time", int'(word_time), e.wt);
        chk("exec", int'(exec), e.ex);
        chk("busy", int'(busy), e.bz);
`ifdef G15_SHORT_LINE_EN
        chk("sl_time", int'(sl_time), e.wt % 4);
`endif
        if (exec && !prev_ex) begin rise_bit = int'(bit_time); rise_word = int'(word_time); end
        if (!exec && prev_ex) begin fall_bit = int'(bit_time); fall_word = int'(word_time); end
        prev_ex = exec;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // advance with one tick every 'per' clks until the model sits at (b, w)
    task automatic adv_to(input int b, input int w, input int per);
        int n = 0;
        while (!(m_bit == b && m_word == w) && n < 20000) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            for (int k = 1; k < per; k++) idle();
            n++;
        end
        if (n >= 20000) chk("adv_timeout", n, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_bit", int'(bit_time), 0);
        chk("rst_word", int'(word_time), 0);
        chk("rst_exec", int'(exec), 0);
        chk("rst_busy", int'(busy), 0);

        ws_cnt = 0;
        repeat (BITS) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("w1_word", int'(word_time), 1);
        chk("w1_ws_cnt", ws_cnt, 1);

        rs_cnt = 0;
        repeat (BITS * (WORDS - 1)) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rev_word", int'(word_time), 0);
        chk("rev_bit", int'(bit_time), 0);
        chk("rev_cnt", rs_cnt, 1);
        chk("rev_at_bit", rs_bit, 28);
        chk("rev_at_word", rs_word, 107);

        // go at bit 5 of word 4, tick every 3 clks
        adv_to(5, 4, 3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("arm_busy", int'(busy), 1);
        chk("arm_exec", int'(exec), 0);
        adv_to(2, 5, 3);
        chk("go_rise_word", rise_word, 5);
        chk("go_rise_bit", rise_bit, 0);
        chk("run_exec", int'(exec), 1);

        // stop at bit 10 of word 7
        adv_to(10, 7, 3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("drain_exec", int'(exec), 1);
        adv_to(1, 8, 3);
        chk("stop_last_hi_word", hi_word, 7);
        chk("stop_last_hi_bit", hi_bit, 28);
        chk("stop_fall_word", fall_word, 8);
        chk("stop_fall_bit", fall_bit, 0);
        chk("stop_busy", int'(busy), 0);

        // single-word step; a stop inside STEP must not shorten it
        adv_to(3, 9, 1);
        ex_ticks = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        adv_to(10, 10, 1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        adv_to(5, 11, 1);
        chk("step_ticks", ex_ticks, 29);
        chk("step_busy", int'(busy), 0);

        // go coinciding with wb in HALT waits a whole word in ARM
        adv_to(28, 12, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("gowb_exec", int'(exec), 0);
        chk("gowb_busy", int'(busy), 1);
        adv_to(0, 14, 1);
        chk("gowb_run", int'(exec), 1);
        // stop coinciding with wb in RUN still drains one more word
        adv_to(28, 14, 1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stopwb_exec", int'(exec), 1);
        adv_to(0, 16, 1);
        chk("stopwb_done", int'(busy), 0);

        // stop while armed, go+stop in HALT, go+step picks run mode
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("armstop_busy", int'(busy), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("gostop_busy", int'(busy), 0);
        chk("gostop_exec", int'(exec), 0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        w = (m_word + 3) % WORDS;
        adv_to(12, w, 1);
        chk("gostep_run", int'(exec), 1);

        // reset mid-RUN at bit 12
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midrst_exec", int'(exec), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_bit", int'(bit_time), 0);
        chk("midrst_word", int'(word_time), 0);

        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 29) == 0),
                  1'($urandom_range(0, 39) == 0),
                  1'($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
